// File: rtl/spi_cmd_pkg.sv
// Opcode map and command classification shared by the framer blocks.
package spi_cmd_pkg;

  localparam logic [7:0] OP_00 = 8'h00;
  localparam logic [7:0] OP_01 = 8'h01;
  localparam logic [7:0] OP_02 = 8'h02;
  localparam logic [7:0] OP_03 = 8'h03;
  localparam logic [7:0] OP_04 = 8'h04;
  localparam logic [7:0] OP_05 = 8'h05;
  localparam logic [7:0] OP_06 = 8'h06;
  localparam logic [7:0] OP_07 = 8'h07;
  localparam logic [7:0] OP_08 = 8'h08;
  localparam logic [7:0] OP_09 = 8'h09;
  localparam logic [7:0] OP_0A = 8'h0A;
  localparam logic [7:0] OP_0B = 8'h0B;

  typedef enum logic [1:0] {
    CLS_NONE     = 2'd0,
    CLS_CAMWRITE = 2'd1,
    CLS_READ     = 2'd2,
    CLS_MEM      = 2'd3
  } cls_e;

  // Map an opcode to the controller that consumes it; anything else is unknown.
  function automatic cls_e classify(input logic [7:0] op);
    case (op)
      OP_01, OP_03, OP_04, OP_05, OP_06, OP_0B: return CLS_CAMWRITE;
      OP_00, OP_02:                             return CLS_READ;
      OP_07, OP_08, OP_09, OP_0A:               return CLS_MEM;
      default:                                  return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_assembler.sv
// Collects SPI bytes into one frame and strobes o_close with the finished
// contents. The close is combinational in the closing cycle (including a byte
// arriving in that same cycle) so the consumer can register it on the same
// edge; the collector then returns to idle with its buffer cleared.
module spi_frame_assembler #(
  parameter int DATA_BYTES   = 8,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = $clog2(DATA_BYTES+2)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_byte,
  input  logic                    i_rx_valid,
  input  logic                    i_frame_end,
  output logic                    o_close,
  output logic [7:0]              o_op,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [CNT_W-1:0]        o_cnt
);

  localparam int IW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TIMEOUT-1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DATA_BYTES+1);

  typedef enum logic {S_IDLE, S_COLLECT} st_e;

  st_e                     r_state, w_state_nxt;
  logic [7:0]              r_op, w_op_nxt;
  logic [8*DATA_BYTES-1:0] r_data, w_data_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IW-1:0]           r_idle;
  logic                    w_close;

  // Collector state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next frame contents with the incoming byte merged, plus close decision.
  // The idle counter holds the number of idle cycles already elapsed, so the
  // IDLE_TIMEOUT-th idle cycle is the one where it reads IDLE_TIMEOUT-1.
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    w_op_nxt    = r_op;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    if (i_rx_valid) begin
      if (r_cnt == '0) w_op_nxt = i_byte;
      for (int b = 1; b <= DATA_BYTES; b++)
        if (r_cnt == CNT_W'(b)) w_data_nxt[8*(DATA_BYTES-b+1)-1 -: 8] = i_byte;
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        // frame_end alone in idle is an empty frame and is ignored
        if (i_rx_valid) begin
          if (i_frame_end) w_close = 1'b1;
          else             w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_frame_end || (!i_rx_valid && r_idle == IDLE_LAST)) begin
          w_close     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame buffer: accumulate bytes, clear once the frame is handed off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op   <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_close) begin
      r_op   <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_op   <= w_op_nxt;
      r_data <= w_data_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Idle counter: restarts on every byte and whenever no frame is open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                      r_idle <= '0;
    else if (i_rx_valid || w_close || r_state == S_IDLE) r_idle <= '0;
    else                                               r_idle <= r_idle + 1'b1;
  end

  assign o_close = w_close;
  assign o_op    = w_op_nxt;
  assign o_data  = w_data_nxt;
  assign o_cnt   = w_cnt_nxt;

endmodule

// File: rtl/spi_cmd_framer.sv
// SPI command framer: classifies closed frames, holds one in an output slot
// until out_ready, and reports unknown opcodes and dropped frames as pulses.
module spi_cmd_framer
  import spi_cmd_pkg::*;
#(
  parameter int DATA_BYTES   = 8,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = $clog2(DATA_BYTES+2)
) (
  input  logic                    sysClk,
  input  logic                    sysRst_n,
  input  logic [7:0]              byte_in,
  input  logic                    rx_valid,
  input  logic                    frame_end,
  input  logic                    out_ready,
  output logic [7:0]              instruction,
  output logic [8*DATA_BYTES-1:0] data,
  output logic [CNT_W-1:0]        byte_count,
  output logic                    valid_camwrite,
  output logic                    valid_read,
  output logic                    valid_mem,
  output logic                    err_unknown,
  output logic                    err_overflow
);

  logic                    w_close;
  logic [7:0]              w_op;
  logic [8*DATA_BYTES-1:0] w_data;
  logic [CNT_W-1:0]        w_cnt;
  cls_e                    w_cls;
  logic                    w_free, w_load;

  logic                    r_slot_vld;
  cls_e                    r_cls;
  logic [7:0]              r_instr;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err_unk, r_err_ovf;

  spi_frame_assembler #(
    .DATA_BYTES  (DATA_BYTES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_asm (
    .i_clk      (sysClk),
    .i_rst_n    (sysRst_n),
    .i_byte     (byte_in),
    .i_rx_valid (rx_valid),
    .i_frame_end(frame_end),
    .o_close    (w_close),
    .o_op       (w_op),
    .o_data     (w_data),
    .o_cnt      (w_cnt)
  );

  assign w_cls  = classify(w_op);
  // The slot may be reloaded in the same cycle the consumer takes it.
  assign w_free = !r_slot_vld || out_ready;
  assign w_load = w_close && (w_cls != CLS_NONE) && w_free;

  // Output slot: load a classified frame, release it on out_ready.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_slot_vld <= 1'b0;
      r_cls      <= CLS_NONE;
      r_instr    <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
    end else if (w_load) begin
      r_slot_vld <= 1'b1;
      r_cls      <= w_cls;
      r_instr    <= w_op;
      r_data     <= w_data;
      r_cnt      <= w_cnt;
    end else if (out_ready) begin
      r_slot_vld <= 1'b0;
    end
  end

  // Single-cycle error pulses for discarded and dropped frames.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_err_unk <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_err_unk <= w_close && (w_cls == CLS_NONE);
      r_err_ovf <= w_close && (w_cls != CLS_NONE) && !w_free;
    end
  end

  assign instruction    = r_instr;
  assign data           = r_data;
  assign byte_count     = r_cnt;
  assign valid_camwrite = r_slot_vld && (r_cls == CLS_CAMWRITE);
  assign valid_read     = r_slot_vld && (r_cls == CLS_READ);
  assign valid_mem      = r_slot_vld && (r_cls == CLS_MEM);
  assign err_unknown    = r_err_unk;
  assign err_overflow   = r_err_ovf;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Scoreboard bench for spi_cmd_framer: directed scenarios then random frames.
module tb_spi_cmd_framer;

  localparam int DB = 8;
  localparam int TO = 16;
  localparam int CW = $clog2(DB+2);

  logic          sysClk, sysRst_n;
  logic [7:0]    byte_in;
  logic          rx_valid, frame_end, out_ready;
  logic [7:0]    instruction;
  logic [8*DB-1:0] data;
  logic [CW-1:0] byte_count;
  logic          valid_camwrite, valid_read, valid_mem, err_unknown, err_overflow;

  spi_cmd_framer #(.DATA_BYTES(DB), .IDLE_TIMEOUT(TO), .CNT_W(CW)) dut (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .byte_in(byte_in), .rx_valid(rx_valid),
    .frame_end(frame_end), .out_ready(out_ready), .instruction(instruction),
    .data(data), .byte_count(byte_count), .valid_camwrite(valid_camwrite),
    .valid_read(valid_read), .valid_mem(valid_mem), .err_unknown(err_unknown),
    .err_overflow(err_overflow)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [7:0]      instr;
    logic [8*DB-1:0] data;
    logic [CW-1:0]   cnt;
    logic [1:0]      cls;   // 1 camwrite, 2 read, 3 mem
  } exp_t;

  exp_t       fq[$];        // frame expected in the output slot
  int         uq[$];        // cycles where err_unknown must pulse
  int         oq[$];        // cycles where err_overflow must pulse
  logic [7:0] m_bytes[$];   // bytes of the frame being received
  logic [7:0] fb[$];        // driver's frame byte list
  logic       m_occ;
  int         cyc;
  int         n_chk, n_fail;
  logic       tb_close;     // driver marks the cycle in which a frame closes
  int         rdy_mode, rdy_pct;

  function automatic logic [1:0] tb_cls(input logic [7:0] op);
    case (op)
      8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0B: return 2'd1;
      8'h00, 8'h02:                             return 2'd2;
      8'h07, 8'h08, 8'h09, 8'h0A:               return 2'd3;
      default:                                  return 2'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sees the inputs of each cycle at the sampling edge.
  always @(posedge sysClk) begin
    exp_t e;
    logic loaded;
    int   n;
    if (!sysRst_n) begin
      m_bytes.delete(); fq.delete(); uq.delete(); oq.delete();
      m_occ = 1'b0;
    end else begin
      if (rx_valid) m_bytes.push_back(byte_in);
      loaded = 1'b0;
      if (tb_close) begin
        n       = m_bytes.size();
        e.instr = m_bytes[0];
        e.data  = '0;
        for (int k = 1; k < n && k <= DB; k++) e.data[8*(DB-k+1)-1 -: 8] = m_bytes[k];
        e.cnt   = CW'((n > DB+1) ? DB+1 : n);
        e.cls   = tb_cls(e.instr);
        if (e.cls == 2'd0)              uq.push_back(cyc+1);
        else if (!m_occ || out_ready) begin fq.push_back(e); loaded = 1'b1; end
        else                            oq.push_back(cyc+1);
        m_bytes.delete();
      end
      if (loaded)         m_occ = 1'b1;
      else if (out_ready) m_occ = 1'b0;
    end
    cyc++;
  end

  // Monitor: compares presented outputs against the scoreboard.
  always @(negedge sysClk) begin
    logic [2:0] v;
    logic       want;
    exp_t       e;
    if (!sysRst_n) begin
      chk("reset_outputs", {instruction, data, byte_count, valid_camwrite, valid_read,
                            valid_mem, err_unknown, err_overflow}, '0);
    end else begin
      v = {valid_camwrite, valid_read, valid_mem};
      if (v != 3'b000 || fq.size() != 0) begin
        if (fq.size() == 0) chk("unexpected_valid", v, 3'b000);
        else begin
          e = fq[0];
          chk("valid_class", v, {e.cls == 2'd1, e.cls == 2'd2, e.cls == 2'd3});
          chk("instruction", instruction, e.instr);
          chk("data", data, e.data);
          chk("byte_count", byte_count, e.cnt);
          if (out_ready) void'(fq.pop_front());
        end
      end
      want = (uq.size() > 0 && uq[0] == cyc);
      if (err_unknown || want) begin
        chk("err_unknown", err_unknown, want);
        if (want) void'(uq.pop_front());
      end
      want = (oq.size() > 0 && oq[0] == cyc);
      if (err_overflow || want) begin
        chk("err_overflow", err_overflow, want);
        if (want) void'(oq.pop_front());
      end
    end
  end

  // Consumer: forced low/high or random acceptance.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge sysClk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 99) < rdy_pct);
      endcase
    end
  end

  task automatic step(input logic v, input logic [7:0] b, input logic fe, input logic cl);
    rx_valid = v; byte_in = b; frame_end = fe; tb_close = cl;
    @(posedge sysClk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Send fb; cmode 0 = separate frame_end, 1 = frame_end with last byte, 2 = timeout.
  task automatic send(input int cmode, input int maxgap);
    int n;
    logic last;
    n = fb.size();
    for (int i = 0; i < n; i++) begin
      last = (i == n-1);
      step(1'b1, fb[i], last && cmode == 1, last && cmode == 1);
      if (!last) idle($urandom_range(0, maxgap));
    end
    if (cmode == 0) begin
      idle($urandom_range(0, maxgap));
      step(1'b0, 8'h00, 1'b1, 1'b1);
    end else if (cmode == 2) begin
      idle(TO-1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int n;
    cyc = 0; n_chk = 0; n_fail = 0; m_occ = 1'b0;
    rdy_mode = 0; rdy_pct = 50;
    sysRst_n = 1'b0; rx_valid = 1'b0; byte_in = 8'h00; frame_end = 1'b0; tb_close = 1'b0;
    repeat (3) @(posedge sysClk);
    #1 sysRst_n = 1'b1;
    idle(2);

    // full camwrite frame, consumer always ready
    rdy_mode = 1;
    fb = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
    send(0, 0); idle(3);
    // short read frame closed by timeout
    fb = '{8'h02, 8'h05};
    send(2, 0); idle(3);
    // slot held, second frame dropped
    rdy_mode = 0; idle(1);
    fb = '{8'h07, 8'h31}; send(0, 0); idle(20);
    fb = '{8'h08, 8'h32}; send(0, 0); idle(2);
    rdy_mode = 1; idle(3);
    // unknown opcode, then frame_end in idle
    fb = '{8'h0C}; send(0, 0); idle(2);
    step(1'b0, 8'h00, 1'b1, 1'b0); idle(3);
    // overlong frame truncated, frame_end with last byte
    fb = '{8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    send(1, 0); idle(3);
    // reset mid-frame, then a clean frame
    for (int i = 0; i < 4; i++) step(1'b1, 8'h03 + 8'(i), 1'b0, 1'b0);
    sysRst_n = 1'b0; idle(3);
    sysRst_n = 1'b1; idle(2);
    fb = '{8'h00, 8'h5A, 8'hA5}; send(0, 0); idle(3);

    // random traffic
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      rdy_pct = $urandom_range(10, 95);
      n = $urandom_range(1, 12);
      fb.delete();
      fb.push_back(8'($urandom_range(0, 13)));
      for (int i = 1; i < n; i++) fb.push_back(8'($urandom));
      send($urandom_range(0, 2), 2);
      if ($urandom_range(0, 4) == 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      idle($urandom_range(0, 3));
    end

    rdy_mode = 1; idle(6);
    chk("scoreboard_drained", 128'(fq.size() + uq.size() + oq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
